pio_mode_sequencer: RTL and testbench

PIO_MODE_SEQUENCER -- requirements
Module: pio_mode_sequencer

---
 rtl/pio_mode_sequencer_if.sv | 31 +++
 rtl/pio_mode_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_pio_mode_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_mode_sequencer_if.sv
// pio_mode_sequencer_if
// Avalon-MM style bus between the mode sequencer and a one-register PIO
// peripheral.
//   avm_address     master->slave  register address (always 0)
//   avm_chipselect  master->slave  peripheral select
//   avm_write_n     master->slave  write strobe, active low
//   avm_writedata   master->slave  write data, bit 0 carries the mode
//   avm_readdata    slave->master  read data, zero wait state
interface pio_mode_sequencer_if;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_chipselect,
        output avm_write_n,
        output avm_writedata,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_chipselect,
        input  avm_write_n,
        input  avm_writedata,
        output avm_readdata
    );
endinterface

// File: rtl/pio_mode_sequencer.sv
// pio_mode_sequencer
// Arbitrates mode-change requests from two requesters (round robin on
// contention), commits the granted mode to a PIO register with a single
// write, holds for SETTLE_CYCLES and then pulses the matching ack. A request
// for the mode already committed is acknowledged without touching the bus.
//
// Optional build macro PIO_MODE_READBACK_CHECK_EN: every write is followed
// by a one-cycle readback; a mismatch sets the sticky err flag and the write
// is retried once. Without the macro err is constant 0.
//
// Ports
//   clk            sole clock, rising edge
//   reset          asynchronous reset, active high
//   req0/req1      level request from requester 0/1
//   mode0/mode1    requested mode, valid while the matching req is high
//   ack0/ack1      single-cycle completion pulse
//   cur_mode       mode most recently committed to the PIO (resets to 1)
//   busy           high whenever the sequencer is not idle
//   err            sticky readback-mismatch flag
//   avm            PIO bus (master side)
//
// state  | meaning
// IDLE   | sample requests, arbitrate, latch granted mode
// WRITE  | one-cycle PIO write of the latched mode
// READ   | one-cycle PIO readback (readback build only)
// SETTLE | hold SETTLE_CYCLES cycles after the write
// ACK    | one-cycle ack to the granted requester
module pio_mode_sequencer #(
    parameter int SETTLE_CYCLES = 16,
    parameter bit RR_INIT       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic mode0,
    input  logic mode1,
    output logic ack0,
    output logic ack1,
    output logic cur_mode,
    output logic busy,
    output logic err,
    pio_mode_sequencer_if.master avm
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
`ifdef PIO_MODE_READBACK_CHECK_EN
        READ,
`endif
        SETTLE,
        ACK
    } state_t;

    localparam state_t     POST_WRITE  = (SETTLE_CYCLES == 0) ? ACK : SETTLE;
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state, state_nxt;
    logic       grant_q;
    logic       mode_q;
    logic       cur_mode_q;
    logic       last_q;
    logic [7:0] cnt_q;
    logic       grant_sel;
    logic       grant_mode;
    logic       any_req;

    // On contention the requester that was not served last wins.
    assign any_req    = req0 | req1;
    assign grant_sel  = (req0 && req1) ? ~last_q : req1;
    assign grant_mode = grant_sel ? mode1 : mode0;

`ifdef PIO_MODE_READBACK_CHECK_EN
    logic err_q;
    logic retry_q;
    logic rd_match;
    logic unused_rd;

    assign rd_match  = (avm.avm_readdata[0] == mode_q);
    assign unused_rd = ^avm.avm_readdata[31:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q   <= 1'b0;
            retry_q <= 1'b0;
        end else if (state == IDLE) begin
            retry_q <= 1'b0;
        end else if (state == READ && !rd_match) begin
            err_q   <= 1'b1;
            retry_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_rd;

    assign unused_rd = ^avm.avm_readdata;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant_q    <= 1'b0;
            mode_q     <= 1'b0;
            cur_mode_q <= 1'b1;
            last_q     <= ~RR_INIT;
            cnt_q      <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                grant_q <= grant_sel;
                mode_q  <= grant_mode;
                last_q  <= grant_sel;
            end
            if (state == WRITE) begin
                cur_mode_q <= mode_q;
            end
            if (state != SETTLE && state_nxt == SETTLE) begin
                cnt_q <= SETTLE_LOAD;
            end else if (state == SETTLE && cnt_q != 8'd0) begin
                cnt_q <= cnt_q - 8'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = (grant_mode == cur_mode_q) ? ACK : WRITE;
                end
            end
`ifdef PIO_MODE_READBACK_CHECK_EN
            WRITE:   state_nxt = READ;
            READ: begin
                if (!rd_match && !retry_q) begin
                    state_nxt = WRITE;
                end else begin
                    state_nxt = POST_WRITE;
                end
            end
`else
            WRITE:   state_nxt = POST_WRITE;
`endif
            SETTLE: begin
                if (cnt_q == 8'd0) begin
                    state_nxt = ACK;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        avm.avm_address    = 2'b00;
        avm.avm_chipselect = 1'b0;
        avm.avm_write_n    = 1'b1;
        avm.avm_writedata  = 32'd0;
        case (state)
            WRITE: begin
                avm.avm_chipselect = 1'b1;
                avm.avm_write_n    = 1'b0;
                avm.avm_writedata  = {31'd0, mode_q};
            end
`ifdef PIO_MODE_READBACK_CHECK_EN
            READ: begin
                avm.avm_chipselect = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    assign ack0     = (state == ACK) && !grant_q;
    assign ack1     = (state == ACK) &&  grant_q;
    assign cur_mode = cur_mode_q;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_pio_mode_sequencer.sv
module tb_pio_mode_sequencer;

    localparam int SETTLE  = 16;
    localparam bit RR_INIT = 1'b0;

    logic clk;
    logic reset;
    logic req0, req1, mode0, mode1;
    logic ack0, ack1, cur_mode, busy, err;
    logic pio_reg;
    logic pio_stuck;

    int n_checks;
    int n_errors;

    // transaction-level reference state
    bit m_cur;
    bit m_last;
    bit m_err;

    pio_mode_sequencer_if avm_bus();

    pio_mode_sequencer #(
        .SETTLE_CYCLES(SETTLE),
        .RR_INIT      (RR_INIT)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .req1    (req1),
        .mode0   (mode0),
        .mode1   (mode1),
        .ack0    (ack0),
        .ack1    (ack1),
        .cur_mode(cur_mode),
        .busy    (busy),
        .err     (err),
        .avm     (avm_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PIO register stand-in, optionally with bit 0 of the readback stuck at 1
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pio_reg <= 1'b1;
        end else if (avm_bus.avm_chipselect && !avm_bus.avm_write_n) begin
            pio_reg <= avm_bus.avm_writedata[0];
        end
    end
    assign avm_bus.avm_readdata = {31'h2AAAAAAA, (pio_stuck ? 1'b1 : pio_reg)};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cur  = 1'b1;
        m_last = ~RR_INIT;
        m_err  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Called at a negedge while the DUT is idle; the next rising edge is the
    // grant edge k, and the n-th following negedge observes cycle k+n.
    task automatic run_txn(input bit r0, input bit r1, input bit m0, input bit m1,
                           input bit keep, input bit drop_mid);
        bit g, gm;
        int exp_ack, exp_wr;
        int ack_n, ack_who, extra_ack, wr_cnt, first_wr, overlap, bus_bad, busy_gap;
        bit done, busy_end;
        logic [31:0] last_wd;

        if (r0 && r1) g = ~m_last;
        else          g = r1;
        m_last = g;
        gm = g ? m1 : m0;
        if (gm == m_cur) begin
            exp_ack = 1;
            exp_wr  = 0;
        end else begin
`ifdef PIO_MODE_READBACK_CHECK_EN
            if ((pio_stuck ? 1'b1 : gm) == gm) begin
                exp_ack = 3 + SETTLE;
                exp_wr  = 1;
            end else begin
                exp_ack = 5 + SETTLE;
                exp_wr  = 2;
                m_err   = 1'b1;
            end
`else
            exp_ack = 2 + SETTLE;
            exp_wr  = 1;
`endif
            m_cur = gm;
        end

        req0 = r0; req1 = r1; mode0 = m0; mode1 = m1;
        ack_n = 0; ack_who = 0; extra_ack = 0; wr_cnt = 0; first_wr = 0;
        overlap = 0; bus_bad = 0; busy_gap = 0; done = 1'b0; busy_end = 1'b1;
        last_wd = 32'hFFFF_FFFF;

        for (int n = 1; n <= SETTLE + 30; n++) begin
            @(negedge clk);
            if (avm_bus.avm_chipselect && !avm_bus.avm_write_n) begin
                wr_cnt++;
                last_wd = avm_bus.avm_writedata;
                if (first_wr == 0) first_wr = n;
            end
            if (!avm_bus.avm_chipselect && (!avm_bus.avm_write_n || avm_bus.avm_writedata != 32'd0))
                bus_bad++;
            if (avm_bus.avm_address != 2'd0) bus_bad++;
            if (ack0 && ack1) overlap++;
            if (ack_n != 0 && n == ack_n + 1) begin
                busy_end = busy;
                if (ack0 || ack1) extra_ack++;
                done = 1'b1;
                break;
            end
            if (ack0 || ack1) begin
                if (ack_n == 0) begin
                    ack_n   = n;
                    ack_who = ack1 ? 1 : 0;
                    if (!keep) begin
                        req0 = 1'b0;
                        req1 = 1'b0;
                    end
                end else begin
                    extra_ack++;
                end
            end
            if (ack_n == 0 && !busy) busy_gap++;
            if (drop_mid && n == 1) begin
                req0  = 1'b0;
                req1  = 1'b0;
                mode0 = ~mode0;
                mode1 = ~mode1;
            end
        end

        if (!done) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end
        check_val("txn_done", {31'd0, done}, 32'd1);
        check_val("ack_cycle", ack_n, exp_ack);
        check_val("ack_grant", ack_who, {31'd0, g});
        check_val("extra_ack", extra_ack, 32'd0);
        check_val("ack_overlap", overlap, 32'd0);
        check_val("write_count", wr_cnt, exp_wr);
        if (exp_wr > 0) begin
            check_val("first_write_cycle", first_wr, 32'd1);
            check_val("writedata", last_wd, {31'd0, gm});
        end
        check_val("bus_idle_values", bus_bad, 32'd0);
        check_val("busy_during", busy_gap, 32'd0);
        check_val("busy_after_ack", {31'd0, busy_end}, 32'd0);
        check_val("cur_mode", {31'd0, cur_mode}, {31'd0, m_cur});
        check_val("err", {31'd0, err}, {31'd0, m_err});
    endtask

    initial begin
        logic [1:0] pat;
        bit         dm;

        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        req0      = 1'b0;
        req1      = 1'b0;
        mode0     = 1'b0;
        mode1     = 1'b0;
        pio_stuck = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        check_val("rst_busy",   {31'd0, busy}, 32'd0);
        check_val("rst_ack0",   {31'd0, ack0}, 32'd0);
        check_val("rst_ack1",   {31'd0, ack1}, 32'd0);
        check_val("rst_cur",    {31'd0, cur_mode}, 32'd1);
        check_val("rst_err",    {31'd0, err}, 32'd0);
        check_val("rst_cs",     {31'd0, avm_bus.avm_chipselect}, 32'd0);
        check_val("rst_wn",     {31'd0, avm_bus.avm_write_n}, 32'd1);
        check_val("rst_wdata",  avm_bus.avm_writedata, 32'd0);
        reset = 1'b0;

        // first request after reset writes mode 0
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // same mode again: acknowledged without bus activity
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // both requesters hold their request continuously from reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            pat = 2'($urandom_range(1, 3));
            dm  = ($urandom_range(0, 3) == 0);
            run_txn(pat[0], pat[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, dm);
        end

        // reset in the middle of SETTLE discards the transaction
        do_reset();
        req0  = 1'b1;
        mode0 = 1'b0;
        repeat (6) @(negedge clk);
        req0  = 1'b0;
        reset = 1'b1;
        #1;
        check_val("midrst_busy",  {31'd0, busy}, 32'd0);
        check_val("midrst_cur",   {31'd0, cur_mode}, 32'd1);
        check_val("midrst_ack",   {30'd0, ack1, ack0}, 32'd0);
        check_val("midrst_cs",    {31'd0, avm_bus.avm_chipselect}, 32'd0);
        check_val("midrst_wn",    {31'd0, avm_bus.avm_write_n}, 32'd1);
        check_val("midrst_wdata", avm_bus.avm_writedata, 32'd0);
        check_val("midrst_err",   {31'd0, err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_txn(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

`ifdef PIO_MODE_READBACK_CHECK_EN
        // readback stuck at 1: writing mode 0 mismatches twice
        do_reset();
        pio_stuck = 1'b1;
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_txn(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_txn(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        pio_stuck = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
